dc_token_ring_writer: RTL and testbench
=======================================

// Module: dc_token_ring_writer
// PURPOSE
//  Writer end of the token/pointer dual-clock channel used on the SoC AXI ports (the *_writetoken / *_readpointer pairs).
//  Accepts payload beats over valid/ready, stores each in a BUFFER_WIDTH-slot register ring, and advances a one-hot write token.
//  The remote reader, in its own clock domain, samples the token and returns a one-hot read pointer.
//  One instance per AXI channel (AW, AR, W on the master side; R, B on the slave side).
// PARAMETERS
//  DATA_WIDTH    32  payload bits per beat (packed AXI channel fields)
//  BUFFER_WIDTH  8   ring slots = token/pointer width; >=3; usable capacity BUFFER_WIDTH-1
//  GLITCH_LIMIT  4   consecutive non-one-hot synced pointer samples before err_o is raised
// PORTS
//  clk_i          in   1                        writer-domain clock
//  rst_i          in   1                        reset, synchronous, active-high
//  valid_i        in   1                        payload beat valid
//  data_i         in   DATA_WIDTH               payload beat
//  ready_o        out  1                        ring not full; beat accepted when valid_i&ready_o
//  writetoken_o   out  BUFFER_WIDTH             one-hot: next slot to be written
//  buffer_o       out  BUFFER_WIDTH*DATA_WIDTH  flattened slot contents; slot k = buffer_o[k*DATA_WIDTH +: DATA_WIDTH]
//  readpointer_i  in   BUFFER_WIDTH             one-hot: next slot the reader consumes; asynchronous to clk_i
//  fill_o         out  $clog2(BUFFER_WIDTH)     occupied slots, as seen through the synchronised pointer
//  err_o          out  1                        sticky: pointer-integrity error
// BEHAVIOUR
//  Reset (rst_i high at a clk_i edge): writetoken_o=1 (slot 0), sync stages and held pointer=1, fill_o=0, err_o=0, glitch count=0.
//   ready_o=1 from the cycle after reset releases. Slot registers are NOT reset; slots never written are undefined.
//  Pointer sync: 2-flop synchroniser on readpointer_i -> rp_s. Held pointer rp_h updates to rp_s only when rp_s is exactly one-hot.
//   Otherwise rp_h keeps its value and the glitch count increments; a one-hot rp_s clears the count.
//   When the count reaches GLITCH_LIMIT, err_o=1 and stays set until reset. err_o never blocks operation.
//  Full/empty, evaluated on writetoken_o and rp_h only:
//   empty when writetoken_o==rp_h.
//   full when rotl1(writetoken_o)==rp_h; ready_o=!full (combinational from registers).
//  Write: on a clk_i edge with valid_i&ready_o, slot[idx(writetoken_o)]<=data_i and writetoken_o<=rotl1(writetoken_o) on the same edge.
//   Both the new slot data and the new token are visible the cycle after the edge.
//   Slot BUFFER_WIDTH-1 wraps to slot 0.
//   valid_i with ready_o=0: no state change. The writer never drops or overwrites an unread slot.
//  fill_o = (idx(writetoken_o) - idx(rp_h)) mod BUFFER_WIDTH, registered, updated each cycle; range 0..BUFFER_WIDTH-1.
//  Simultaneous write and pointer advance in one cycle: both apply. fill_o reflects both next cycle; ready_o may stay 1.
//  Reader may advance several slots between samples; any one-hot rp_s is accepted. No ordering check is made.
//  Latency: reader advance -> ready_o/fill_o update = 3 clk_i edges (2 sync + held reg); fill_o adds 1 more edge.
//  Reset mid-operation: all buffered beats are discarded; the remote reader must be reset in the same window.
//  rst_i has priority over every other input.
// TESTING (BUFFER_WIDTH=8, DATA_WIDTH=32, GLITCH_LIMIT=4)
//  1 Reset, readpointer_i=8'h01, push 7 beats 0xA0..0xA6 -> writetoken_o 01,02,..,80; ready_o=0 after 7th; fill_o=7; slots 0..6 hold A0..A6.
//  2 From full, hold valid_i=1 with data 0xFF for 10 cycles -> no token change, slot 7 unwritten, ready_o=0 throughout.
//  3 From full, set readpointer_i=8'h04 -> ready_o=1 exactly 3 edges later; fill_o=5 one edge after that; 2 more beats accepted, then full.
//  4 Continuous push while readpointer_i advances one slot every 3 cycles for 40 beats -> token wraps 80->01; reader-side scoreboard gets all 40 beats in order.
//  5 Drive readpointer_i=8'h06 for 3 cycles, then 8'h04 -> rp_h unchanged, err_o=0; drive 8'h00 for 6 cycles -> err_o=1 and stays 1 after a valid pointer returns.
//  6 Assert rst_i while fill_o=5 and valid_i=1 -> next cycle writetoken_o=01, fill_o=0, err_o=0, no beat accepted during the reset cycle.

Source files
------------

// File: rtl/dc_token_ring_writer.sv
// Writer end of a token/pointer dual-clock ring: stores beats in register slots and rotates a one-hot write token.
// Latency: a beat is visible in buffer_o/writetoken_o 1 edge after acceptance; a reader advance reaches ready_o after 3 edges and fill_o after 4.
// Backpressure: ready_o drops when the next token position equals the held read pointer; a stalled beat changes no state.
module dc_token_ring_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = 8,
  parameter int GLITCH_LIMIT = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               valid_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  output logic                               ready_o,
  output logic [BUFFER_WIDTH-1:0]            writetoken_o,
  output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] buffer_o,
  input  logic [BUFFER_WIDTH-1:0]            readpointer_i,
  output logic [$clog2(BUFFER_WIDTH)-1:0]    fill_o,
  output logic                               err_o
);

  localparam int IDX_W = $clog2(BUFFER_WIDTH);
  localparam int CNT_W = $clog2(GLITCH_LIMIT + 1);
  localparam logic [CNT_W-1:0] GLIM = CNT_W'(GLITCH_LIMIT);
  localparam logic [IDX_W:0]   BW_L = (IDX_W + 1)'(BUFFER_WIDTH);
  localparam logic [BUFFER_WIDTH-1:0] SLOT0 = BUFFER_WIDTH'(1);

  // One-hot to slot index; callers only pass vectors known to be one-hot.
  function automatic logic [IDX_W-1:0] oh2idx(input logic [BUFFER_WIDTH-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < BUFFER_WIDTH; k++) begin
      if (oh[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  logic [BUFFER_WIDTH-1:0] wt_q, wt_d;
  logic [BUFFER_WIDTH-1:0] s1_q, s1_d;
  logic [BUFFER_WIDTH-1:0] s2_q, s2_d;
  logic [BUFFER_WIDTH-1:0] rp_h_q, rp_h_d;
  logic [IDX_W-1:0]        fill_q, fill_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        gcnt_q, gcnt_d;
  logic [DATA_WIDTH-1:0]   slot_q [BUFFER_WIDTH];
  logic [DATA_WIDTH-1:0]   slot_d [BUFFER_WIDTH];

  logic                    full;
  logic                    accept;
  logic [IDX_W:0]          wt_idx;
  logic [IDX_W:0]          rp_idx;

  // Full/ready come only from registered token and held pointer, never from raw synced samples.
  always_comb begin
    full   = ({wt_q[BUFFER_WIDTH-2:0], wt_q[BUFFER_WIDTH-1]} == rp_h_q);
    accept = valid_i & ~full & ~rst_i;
    wt_idx = {1'b0, oh2idx(wt_q)};
    rp_idx = {1'b0, oh2idx(rp_h_q)};
  end

  // Next-state: pointer sync and hold, glitch tracking, token advance, occupancy.
  always_comb begin
    s1_d   = readpointer_i;
    s2_d   = s1_q;
    rp_h_d = rp_h_q;
    gcnt_d = gcnt_q;
    wt_d   = wt_q;
    if ($countones(s2_q) == 1) begin
      rp_h_d = s2_q;
      gcnt_d = '0;
    end else if (gcnt_q != GLIM) begin
      gcnt_d = gcnt_q + CNT_W'(1);
    end
    err_d = err_q | (gcnt_d == GLIM);
    if (accept) begin
      wt_d = {wt_q[BUFFER_WIDTH-2:0], wt_q[BUFFER_WIDTH-1]};
    end
    if (wt_idx >= rp_idx) begin
      fill_d = IDX_W'(wt_idx - rp_idx);
    end else begin
      fill_d = IDX_W'(wt_idx + BW_L - rp_idx);
    end
  end

  // Slot write: only the slot under the token changes, and only on an accepted beat.
  always_comb begin
    for (int k = 0; k < BUFFER_WIDTH; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (accept) begin
      slot_d[wt_idx[IDX_W-1:0]] = data_i;
    end
  end

  // Control state; reset points token, sync stages and held pointer at slot 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wt_q   <= SLOT0;
      s1_q   <= SLOT0;
      s2_q   <= SLOT0;
      rp_h_q <= SLOT0;
      fill_q <= '0;
      err_q  <= 1'b0;
      gcnt_q <= '0;
    end else begin
      wt_q   <= wt_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      rp_h_q <= rp_h_d;
      fill_q <= fill_d;
      err_q  <= err_d;
      gcnt_q <= gcnt_d;
    end
  end

  // Slot storage is deliberately unreset; the reader only looks at slots behind the token.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BUFFER_WIDTH; k++) begin
      slot_q[k] <= slot_d[k];
    end
  end

  // Flatten slots for the remote reader.
  always_comb begin
    for (int k = 0; k < BUFFER_WIDTH; k++) begin
      buffer_o[k*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
    end
  end

  assign ready_o      = ~full;
  assign writetoken_o = wt_q;
  assign fill_o       = fill_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_dc_token_ring_writer.sv
// Bench for dc_token_ring_writer: directed scenarios plus random payloads against a slot-index model.
// The model tracks write/read slot indices and delays the raw pointer by two samples before holding it.
// Outputs are compared on every falling edge; literal checks pin the scenario milestones.
module tb_dc_token_ring_writer;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int GL = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            valid_i = 1'b0;
  logic [DW-1:0]   data_i = '0;
  logic            ready_o;
  logic [BW-1:0]   writetoken_o;
  logic [BW*DW-1:0] buffer_o;
  logic [BW-1:0]   readpointer_i = 8'h01;
  logic [2:0]      fill_o;
  logic            err_o;

  int checks = 0;
  int failures = 0;

  dc_token_ring_writer #(.DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .GLITCH_LIMIT(GL)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .writetoken_o(writetoken_o), .buffer_o(buffer_o), .readpointer_i(readpointer_i),
    .fill_o(fill_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slot indices, pointer sample history, glitch run length.
  int          m_wr = 0;
  int          m_rd = 0;
  int          m_gc = 0;
  int          m_fill = 0;
  bit          m_err = 0;
  bit          m_valid = 0;
  logic [DW-1:0] m_slot [BW];
  bit          m_written [BW];
  logic [BW-1:0] samp [$];

  initial begin
    for (int k = 0; k < BW; k++) m_written[k] = 0;
  end

  always @(posedge clk) begin : model
    int nf;
    bit acc;
    logic [BW-1:0] c;
    if (rst_i) begin
      m_wr = 0; m_rd = 0; m_gc = 0; m_err = 0; m_fill = 0;
      samp = '{8'h01, 8'h01};
      m_valid = 1;
    end else if (m_valid) begin
      acc = valid_i && (((m_wr + 1) % BW) != m_rd);
      nf = (m_wr - m_rd + BW) % BW;
      c = samp[1];
      if ($countones(c) == 1) begin
        for (int k = 0; k < BW; k++) if (c[k]) m_rd = k;
        m_gc = 0;
      end else begin
        if (m_gc < GL) m_gc++;
        if (m_gc >= GL) m_err = 1;
      end
      if (acc) begin
        m_slot[m_wr] = data_i;
        m_written[m_wr] = 1;
        m_wr = (m_wr + 1) % BW;
      end
      m_fill = nf;
      samp.push_front(readpointer_i);
      void'(samp.pop_back());
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready", 64'(ready_o), 64'(((m_wr + 1) % BW) != m_rd));
      chk("token", 64'(writetoken_o), 64'(1 << m_wr));
      chk("fill", 64'(fill_o), 64'(m_fill));
      chk("err", 64'(err_o), 64'(m_err));
      for (int k = 0; k < BW; k++) begin
        if (m_written[k]) chk($sformatf("slot%0d", k), 64'(buffer_o[k*DW +: DW]), 64'(m_slot[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] expq [$];
  int rd, pushed, got;
  bit acc, wrapped;
  logic [BW-1:0] wt_prev;

  initial begin
    // 1: reset and fill to capacity
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_token", 64'(writetoken_o), 64'h01);
    chk("rst_fill", 64'(fill_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_ready", 64'(ready_o), 64'h1);
    for (int i = 0; i < 7; i++) begin
      valid_i = 1'b1;
      data_i = 32'hA0 + 32'(i);
      tick();
      chk($sformatf("push_token%0d", i), 64'(writetoken_o), 64'(1 << (i + 1)));
    end
    chk("full_ready", 64'(ready_o), 64'h0);
    valid_i = 1'b0;
    tick();
    chk("full_fill", 64'(fill_o), 64'h7);
    for (int k = 0; k < 7; k++) chk($sformatf("lit_slot%0d", k), 64'(buffer_o[k*DW +: DW]), 64'(32'hA0 + 32'(k)));

    // 2: push against a full ring
    valid_i = 1'b1;
    data_i = 32'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_ready", 64'(ready_o), 64'h0);
      chk("stall_token", 64'(writetoken_o), 64'h80);
    end
    valid_i = 1'b0;

    // 3: reader frees two slots
    readpointer_i = 8'h04;
    tick(); chk("rp_e1_ready", 64'(ready_o), 64'h0);
    tick(); chk("rp_e2_ready", 64'(ready_o), 64'h0);
    tick(); chk("rp_e3_ready", 64'(ready_o), 64'h1);
    tick(); chk("rp_fill5", 64'(fill_o), 64'h5);
    valid_i = 1'b1; data_i = 32'hB0; tick();
    data_i = 32'hB1; tick();
    valid_i = 1'b0;
    chk("refill_token", 64'(writetoken_o), 64'h02);
    chk("refill_ready", 64'(ready_o), 64'h0);

    // 4: streaming with a reader advancing every third cycle
    expq = '{32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hB0, 32'hB1};
    rd = 2; pushed = 0; got = 0; wrapped = 0; wt_prev = writetoken_o;
    valid_i = 1'b1; data_i = $urandom;
    for (int cyc = 0; cyc < 3000 && (pushed < 40 || expq.size() > 0); cyc++) begin
      acc = valid_i && ready_o;
      tick();
      if (acc) begin expq.push_back(data_i); pushed++; end
      if (pushed < 40) begin valid_i = 1'b1; data_i = $urandom; end
      else valid_i = 1'b0;
      if (cyc % 3 == 2 && writetoken_o != 8'(1 << rd)) begin
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_underflow actual=beat_present required=none");
        end else begin
          chk("rd_beat", 64'(buffer_o[rd*DW +: DW]), 64'(expq.pop_front()));
        end
        got++;
        rd = (rd + 1) % BW;
        readpointer_i = 8'(1 << rd);
      end
      if (wt_prev == 8'h80 && writetoken_o == 8'h01) wrapped = 1;
      wt_prev = writetoken_o;
    end
    valid_i = 1'b0;
    chk("stream_pushed", 64'(pushed), 64'd40);
    chk("stream_read", 64'(got), 64'd47);
    chk("stream_wrap", 64'(wrapped), 64'h1);
    repeat (5) tick();

    // 5: non-one-hot pointer samples
    readpointer_i = 8'h06;
    repeat (3) tick();
    readpointer_i = 8'h04;
    repeat (4) tick();
    chk("glitch_short_err", 64'(err_o), 64'h0);
    readpointer_i = 8'h00;
    repeat (5) tick();
    chk("glitch_pre_err", 64'(err_o), 64'h0);
    tick();
    chk("glitch_err", 64'(err_o), 64'h1);
    readpointer_i = 8'h04;
    repeat (4) tick();
    chk("glitch_sticky", 64'(err_o), 64'h1);

    // 6: reset while partly full with a beat offered
    rst_i = 1'b1; readpointer_i = 8'h01;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; data_i = 32'hC0 + 32'(i);
      tick();
    end
    valid_i = 1'b0;
    tick();
    chk("pre_rst_fill", 64'(fill_o), 64'h5);
    rst_i = 1'b1; valid_i = 1'b1; data_i = 32'hEE;
    tick();
    chk("mid_rst_token", 64'(writetoken_o), 64'h01);
    chk("mid_rst_fill", 64'(fill_o), 64'h0);
    chk("mid_rst_err", 64'(err_o), 64'h0);
    rst_i = 1'b0; valid_i = 1'b0;
    tick();
    chk("post_rst_token", 64'(writetoken_o), 64'h01);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
